rms_square_accumulator: RTL and testbench



---
 rtl/rms_square_accumulator.sv | 66 ++++++
 tb/tb_rms_square_accumulator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rms_square_accumulator.sv
// rms_square_accumulator: squares signed samples and emits the sum of each 2^BUF_BIT_W-sample window
module rms_square_accumulator #(
    parameter int DATA_W    = 16,
    parameter int BUF_BIT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic [DATA_W-1:0]               sample_i,
    input  logic                            sample_valid_i,
    output logic [2*DATA_W+BUF_BIT_W-1:0]   sum_o,
    output logic                            sum_update_o,
    output logic [BUF_BIT_W-1:0]            count_o
);
    localparam int SQ_W  = 2 * DATA_W;
    localparam int SUM_W = SQ_W + BUF_BIT_W;

    logic              clear;
    logic [SQ_W-1:0]   s_ext;
    logic [SQ_W-1:0]   sq_r;
    logic              sq_v;
    logic [SUM_W-1:0]  acc;
    logic [SUM_W-1:0]  acc_next;
    logic [BUF_BIT_W-1:0] cnt;

    // The low 2*DATA_W bits of the sign-extended product equal the signed square,
    // which is always non-negative and fits unsigned in 2*DATA_W bits.
    assign clear    = rst | clr;
    assign s_ext    = {{DATA_W{sample_i[DATA_W-1]}}, sample_i};
    assign acc_next = acc + {{BUF_BIT_W{1'b0}}, sq_r};
    assign count_o  = cnt;

    // Stage 1: register the square of each accepted sample
    always_ff @(posedge clk) begin
        if (clear) begin
            sq_r <= '0;
            sq_v <= 1'b0;
        end else begin
            sq_v <= sample_valid_i;
            if (sample_valid_i) sq_r <= s_ext * s_ext;
        end
    end

    // Stage 2: accumulate squares and publish the total when the window closes
    always_ff @(posedge clk) begin
        if (clear) begin
            acc          <= '0;
            cnt          <= '0;
            sum_o        <= '0;
            sum_update_o <= 1'b0;
        end else begin
            sum_update_o <= 1'b0;
            if (sq_v) begin
                if (cnt == '1) begin
                    sum_o        <= acc_next;
                    sum_update_o <= 1'b1;
                    acc          <= '0;
                    cnt          <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rms_square_accumulator.sv
// tb_rms_square_accumulator: directed scoreboard bench for N=4 and N=256 instances
module tb_rms_square_accumulator;
    logic        clk = 1'b0;
    logic        rst, clr, valid;
    logic [15:0] smp;
    logic [33:0] sum4;
    logic        up4;
    logic [1:0]  cnt4;
    logic [39:0] sum8;
    logic        up8;
    logic [7:0]  cnt8;

    always #5 clk = ~clk;

    rms_square_accumulator #(.DATA_W(16), .BUF_BIT_W(2)) d4 (
        .clk(clk), .rst(rst), .clr(clr), .sample_i(smp), .sample_valid_i(valid),
        .sum_o(sum4), .sum_update_o(up4), .count_o(cnt4));

    rms_square_accumulator d8 (
        .clk(clk), .rst(rst), .clr(clr), .sample_i(smp), .sample_valid_i(valid),
        .sum_o(sum8), .sum_update_o(up8), .count_o(cnt8));

    typedef struct {
        longint sum;
        int     due;
    } exp_t;

    exp_t   q[2][$];
    longint macc[2];
    int     mn[2];
    int     mcnt[2];
    bit     mpend[2];
    longint last[2];
    int     cyc = 0;
    int     pass = 0;
    int     total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one edge: update the reference model with the presented inputs, then check both DUTs
    task automatic step();
        for (int i = 0; i < 2; i++) begin
            int n = (i == 0) ? 4 : 256;
            if (rst || clr) begin
                macc[i] = 0; mn[i] = 0; mcnt[i] = 0; mpend[i] = 0; last[i] = 0;
                q[i].delete();
            end else begin
                if (mpend[i]) mcnt[i] = (mcnt[i] == n - 1) ? 0 : mcnt[i] + 1;
                mpend[i] = valid;
                if (valid) begin
                    longint s = longint'($signed(smp));
                    macc[i] += s * s;
                    mn[i]++;
                    if (mn[i] == n) begin
                        exp_t e;
                        e.sum = macc[i];
                        e.due = cyc + 2;
                        q[i].push_back(e);
                        macc[i] = 0;
                        mn[i] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            logic        up   = (i == 0) ? up4 : up8;
            logic [63:0] sum  = (i == 0) ? 64'(sum4) : 64'(sum8);
            logic [63:0] cnt  = (i == 0) ? 64'(cnt4) : 64'(cnt8);
            logic        eup  = (q[i].size() > 0) && (q[i][0].due == cyc);
            chk(i == 0 ? "count4" : "count256", cnt, 64'(mcnt[i]));
            chk(i == 0 ? "strobe4" : "strobe256", 64'(up), 64'(eup));
            if (up && q[i].size() > 0) begin
                exp_t e = q[i].pop_front();
                chk(i == 0 ? "sum4" : "sum256", sum, 64'(e.sum));
                last[i] = e.sum;
            end else if (!up) begin
                chk(i == 0 ? "hold4" : "hold256", sum, 64'(last[i]));
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic c);
        valid = v; smp = s; clr = c;
        step();
        valid = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; clr = 1'b0; smp = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; valid = 1'b1; smp = 16'd100;
        for (int i = 0; i < 3; i++) step();
        chk("reset_sum4", 64'(sum4), 64'd0);
        chk("reset_up4", 64'(up4), 64'd0);
        chk("reset_cnt8", 64'(cnt8), 64'd0);
        rst = 1'b0; valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b0);
        chk("single_cnt_wrap", 64'(cnt4), 64'd3);
        step();
        chk("single_up", 64'(up4), 64'd1);
        chk("single_sum", 64'(sum4), 64'd30);
        chk("single_cnt_zero", 64'(cnt4), 64'd0);
        for (int i = 0; i < 3; i++) step();

        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 1'b0);
            if (i == 5) for (int g = 0; g < 3; g++) drive(1'b0, 16'hdead, 1'b0);
        end
        chk("cont_hold30", 64'(sum4), 64'd30);
        step();
        chk("cont_sum174", 64'(sum4), 64'd174);
        for (int i = 0; i < 4; i++) step();

        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, (i % 2) ? 16'hfffd : 16'd3, 1'b0);
        step();
        chk("mixed_sum", 64'(sum4), 64'd36);

        do_reset();
        for (int i = 0; i < 256; i++) drive(1'b1, 16'h8000, 1'b0);
        step();
        chk("fullscale_up", 64'(up8), 64'd1);
        chk("fullscale_sum", 64'(sum8), 64'd274877906944);
        step();

        do_reset();
        drive(1'b1, 16'd5, 1'b0);
        drive(1'b1, 16'd5, 1'b0);
        drive(1'b1, 16'd7, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd3, 1'b0);
        step();
        chk("clr_sum36", 64'(sum4), 64'd36);
        for (int i = 0; i < 3; i++) step();

        do_reset();
        drive(1'b1, 16'd9, 1'b0);
        drive(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'd1, 1'b0);
        step();
        chk("inflight_sum4", 64'(sum4), 64'd4);
        for (int i = 0; i < 3; i++) step();

        chk("pending4", 64'(q[0].size()), 64'd0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
